// File: rtl/hazard_ctrl.sv
// Hazard control for a 5-stage in-order pipeline: RAW detection against a
// 3-deep in-flight write scoreboard, branch flush, and HALT drain sequencing.
`timescale 1ns/1ps
module hazard_ctrl (
    input  logic        clk_pi,
    input  logic        reset_pi,
    input  logic        id_valid_pi,
    input  logic [4:0]  id_rs_pi,
    input  logic [4:0]  id_rt_pi,
    input  logic        id_use_rs_pi,
    input  logic        id_use_rt_pi,
    input  logic [4:0]  id_dest_pi,
    input  logic        id_we_pi,
    input  logic        id_halt_pi,
    input  logic        mem_taken_pi,
    output logic        stall_po,
    output logic        bubble_po,
    output logic        flush_po,
    output logic        halted_po,
    output logic [1:0]  state_po,
    output logic [15:0] stall_cnt_po
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_drain_cnt;
    logic [1:0]  w_drain_cnt_nxt;
    logic        r_halted;
    logic [15:0] r_stall_cnt;

    logic        r_ex_v;
    logic        r_mem_v;
    logic        r_wb_v;
    logic [4:0]  r_ex_rd;
    logic [4:0]  r_mem_rd;
    logic [4:0]  r_wb_rd;

    logic        w_rs_hit;
    logic        w_rt_hit;
    logic        w_hazard;
    logic        w_issue;
    logic        w_stall;
    logic        w_bubble;
    logic        w_flush;
    logic        w_halt_go;

    // WB is checked too: the register file write lands after the ID read.
    function automatic logic src_hit(
        input logic       use_src,
        input logic [4:0] src,
        input logic       ex_v,
        input logic [4:0] ex_rd,
        input logic       mem_v,
        input logic [4:0] mem_rd,
        input logic       wb_v,
        input logic [4:0] wb_rd
    );
        logic hit;
        hit = 1'b0;
        if (use_src && (src != 5'd0)) begin
            hit = (ex_v && (ex_rd == src)) ||
                  (mem_v && (mem_rd == src)) ||
                  (wb_v && (wb_rd == src));
        end
        return hit;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    assign w_rs_hit = src_hit(id_use_rs_pi, id_rs_pi, r_ex_v, r_ex_rd,
                              r_mem_v, r_mem_rd, r_wb_v, r_wb_rd);
    assign w_rt_hit = src_hit(id_use_rt_pi, id_rt_pi, r_ex_v, r_ex_rd,
                              r_mem_v, r_mem_rd, r_wb_v, r_wb_rd);
    assign w_hazard = id_valid_pi & (w_rs_hit | w_rt_hit);

    // Pipeline control; forced quiet while reset is held.
    always_comb begin
        w_stall = 1'b0;
        w_flush = 1'b0;
        if (reset_pi) begin
            case (r_state)
                ST_RUN: begin
                    w_flush = mem_taken_pi;
                    w_stall = w_hazard & ~mem_taken_pi;
                end
                ST_DRAIN: begin
                    w_flush = mem_taken_pi;
                    w_stall = ~mem_taken_pi;
                end
                default: begin
                    w_flush = 1'b0;
                    w_stall = 1'b1;
                end
            endcase
        end
    end

    assign w_bubble = w_stall;

    // HALT issues as a non-writing instruction.
    assign w_issue = (r_state == ST_RUN) & id_valid_pi & id_we_pi & ~id_halt_pi &
                     (id_dest_pi != 5'd0) & ~w_stall & ~w_flush;

    assign w_halt_go = id_valid_pi & id_halt_pi & ~w_hazard & ~mem_taken_pi;

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_halt_go) begin
                    w_state_nxt     = ST_DRAIN;
                    w_drain_cnt_nxt = 2'd0;
                end
            end
            ST_DRAIN: begin
                if (mem_taken_pi) begin
                    w_state_nxt     = ST_RUN;
                    w_drain_cnt_nxt = 2'd0;
                end else if (r_drain_cnt == 2'd2) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + 2'd1;
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt     = ST_RUN;
                w_drain_cnt_nxt = 2'd0;
            end
        endcase
    end

    // Control state and scoreboard valid bits.
    always_ff @(posedge clk_pi or negedge reset_pi) begin
        if (!reset_pi) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= 2'd0;
            r_halted    <= 1'b0;
            r_stall_cnt <= 16'd0;
            r_ex_v      <= 1'b0;
            r_mem_v     <= 1'b0;
            r_wb_v      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_halted    <= (w_state_nxt == ST_HALTED);
            r_wb_v      <= r_mem_v;
            r_mem_v     <= r_ex_v & ~w_flush;
            r_ex_v      <= w_issue;
            if ((r_state == ST_RUN) && w_stall) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
        end
    end

    // Destination tags are qualified by the valid bits, so they need no reset.
    always_ff @(posedge clk_pi) begin
        r_ex_rd  <= id_dest_pi;
        r_mem_rd <= r_ex_rd;
        r_wb_rd  <= r_mem_rd;
    end

    assign stall_po     = w_stall;
    assign bubble_po    = w_bubble;
    assign flush_po     = w_flush;
    assign halted_po    = r_halted;
    assign state_po     = r_state;
    assign stall_cnt_po = r_stall_cnt;

endmodule
